// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES-128 reverse-order key schedule.
// Rcon is indexed by round 1..10; index 0 and out-of-range values return zero.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    SERVE  = 2'd2
  } state_e;

  localparam logic [3:0] NR = 4'd10;

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] rc;
    case (rnd)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, one byte in, one byte out.
// Byte n of the table sits at bits [(255-n)*8 +: 8], i.e. index {~in, 3'b000}.
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_o = SBOX[{~in_i, 3'b000} +: 8];

endmodule

// File: rtl/aes_inv_key_schedule.sv
// AES-128 round-key generator that streams K10 down to K0, recomputing each
// earlier key from the current one so only a single 128-bit key is held.
//
// state  | meaning
// IDLE   | waiting for a key, key_ready_o high
// EXPAND | forward schedule, one round per cycle, rnd 1..10
// SERVE  | rk_out_o valid; each handshake steps back one round
module aes_inv_key_schedule
  import aes_pkg::*;
(
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         key_valid_i,
  output logic         key_ready_o,
  input  logic [127:0] key_in_i,
  input  logic         key_is_last_i,
  output logic         rk_valid_o,
  input  logic         rk_ready_i,
  output logic [127:0] rk_out_o,
  output logic [3:0]   rk_round_o,
  output logic         rk_last_o
);

  state_e       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] key_q, key_d;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] w1p, w2p, w3p;
  logic [31:0] sub_in, sub_out, t;
  logic [127:0] fwd_key, inv_key;

  assign {w0, w1, w2, w3} = key_q;

  assign w3p = w3 ^ w2;
  assign w2p = w2 ^ w1;
  assign w1p = w1 ^ w0;

  // One SubWord unit serves both directions; only the word feeding it differs.
  assign sub_in = (state_q == EXPAND) ? rot_word(w3) : rot_word(w3p);

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .in_i  (sub_in[8*i +: 8]),
      .out_o (sub_out[8*i +: 8])
    );
  end

  assign t = sub_out ^ {rcon(rnd_q), 24'h0};

  always_comb begin
    logic [31:0] f0, f1, f2, f3;
    f0 = w0 ^ t;
    f1 = w1 ^ f0;
    f2 = w2 ^ f1;
    f3 = w3 ^ f2;
    fwd_key = {f0, f1, f2, f3};
    inv_key = {w0 ^ t, w1p, w2p, w3p};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      key_q   <= 128'd0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      key_q   <= key_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (key_valid_i) state_d = key_is_last_i ? SERVE : EXPAND;
      EXPAND:  if (rnd_q == NR) state_d = SERVE;
      SERVE:   if (rk_ready_i && rnd_q == 4'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rnd_d = rnd_q;
    key_d = key_q;
    case (state_q)
      IDLE: begin
        if (key_valid_i) begin
          key_d = key_in_i;
          rnd_d = key_is_last_i ? NR : 4'd1;
        end
      end
      EXPAND: begin
        key_d = fwd_key;
        if (rnd_q != NR) rnd_d = rnd_q + 4'd1;
      end
      SERVE: begin
        if (rk_ready_i && rnd_q != 4'd0) begin
          key_d = inv_key;
          rnd_d = rnd_q - 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    key_ready_o = (state_q == IDLE);
    rk_valid_o  = (state_q == SERVE);
    rk_last_o   = (state_q == SERVE) && (rnd_q == 4'd0);
    rk_out_o    = key_q;
    rk_round_o  = rnd_q;
  end

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Scoreboard bench for aes_inv_key_schedule: a forward-expansion reference
// model built from a computed S-box queues K10..K0 at each accepted load.
module tb_aes_inv_key_schedule;

  logic         clk = 1'b0;
  logic         reset;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_in;
  logic         key_is_last;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_last;

  always #5 clk = ~clk;

  aes_inv_key_schedule dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .key_valid_i   (key_valid),
    .key_ready_o   (key_ready),
    .key_in_i      (key_in),
    .key_is_last_i (key_is_last),
    .rk_valid_o    (rk_valid),
    .rk_ready_i    (rk_ready),
    .rk_out_o      (rk_out),
    .rk_round_o    (rk_round),
    .rk_last_o     (rk_last)
  );

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SEQ_K10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  int errors = 0;
  int checks = 0;

  logic [7:0]   sb [256];
  logic [127:0] rk_model [11];
  logic [131:0] exp_q [$];
  logic [127:0] first_rk;
  logic [127:0] k1_seen;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic build_model(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    {w[0], w[1], w[2], w[3]} = k;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
        rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++)
      rk_model[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic load(input logic [127:0] k0, input bit last);
    int n = 0;
    build_model(k0);
    while (!key_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (key_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_ready_timeout: key_ready=%b required 1", key_ready);
    end
    key_in      = last ? rk_model[10] : k0;
    key_is_last = last;
    key_valid   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    for (int r = 10; r >= 0; r--) exp_q.push_back({4'(r), rk_model[r]});
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!rk_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (rk_valid !== 1'b1) begin
      errors++;
      $display("FAIL rk_valid_timeout: rk_valid=%b required 1", rk_valid);
    end
  endtask

  task automatic drain(input bit random_ready, input bit inject, input int stop_round,
                       output int beats);
    logic [127:0] prev_out = '0;
    logic [3:0]   prev_round = '0;
    logic [131:0] e;
    bit stalled = 0;
    bit done = 0;
    bit stopped = 0;
    int cyc = 0;
    beats = 0;
    while (!done && !stopped && cyc < 300) begin
      if (stalled) begin
        checks++;
        if (rk_out !== prev_out || rk_round !== prev_round) begin
          errors++;
          $display("FAIL stall_hold: rk_out=%h rk_round=%0d required rk_out=%h rk_round=%0d",
                   rk_out, rk_round, prev_out, prev_round);
        end
      end
      if (stop_round >= 0 && rk_valid && rk_round == 4'(stop_round)) begin
        rk_ready = 1'b0;
        stopped  = 1;
      end else begin
        rk_ready    = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        key_valid   = inject && (beats == 4);
        key_in      = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        key_is_last = 1'b0;
        if (rk_valid && rk_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_beat: rk_round=%0d required no beat", rk_round);
          end else begin
            e = exp_q.pop_front();
            checks++;
            if ({rk_round, rk_out} !== e) begin
              errors++;
              $display("FAIL beat: rk_round=%0d rk_out=%h required rk_round=%0d rk_out=%h",
                       rk_round, rk_out, e[131:128], e[127:0]);
            end
            checks++;
            if (rk_last !== (e[131:128] == 4'd0)) begin
              errors++;
              $display("FAIL rk_last: rk_last=%b at round %0d required %b",
                       rk_last, e[131:128], e[131:128] == 4'd0);
            end
          end
          if (beats == 0) first_rk = rk_out;
          if (rk_round == 4'd1) k1_seen = rk_out;
          beats++;
          if (rk_last) done = 1;
        end
        stalled    = rk_valid && !rk_ready;
        prev_out   = rk_out;
        prev_round = rk_round;
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end
    end
    key_valid = 1'b0;
    if (!stopped) begin
      checks++;
      if (!done || key_ready !== 1'b1 || rk_valid !== 1'b0) begin
        errors++;
        $display("FAIL end_of_sequence: done=%0d key_ready=%b rk_valid=%b required 1 1 0",
                 done, key_ready, rk_valid);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    key_valid = 1'b0;
    rk_ready  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (key_ready !== 1'b1 || rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: key_ready=%b rk_valid=%b required 1 0", key_ready, rk_valid);
    end
    exp_q.delete();
  endtask

  task automatic check_beats(input string name, input int beats);
    checks++;
    if (beats != 11 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_beats: beats=%0d leftover=%0d required 11 0", name, beats, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (key_ready !== 1'b1) begin errors++; $display("FAIL reset_key_ready: %b required 1", key_ready); end
    checks++;
    if (rk_valid !== 1'b0) begin errors++; $display("FAIL reset_rk_valid: %b required 0", rk_valid); end
    checks++;
    if (rk_last !== 1'b0) begin errors++; $display("FAIL reset_rk_last: %b required 0", rk_last); end
    checks++;
    if (rk_round !== 4'd0) begin errors++; $display("FAIL reset_rk_round: %0d required 0", rk_round); end
    checks++;
    if (rk_out !== 128'd0) begin errors++; $display("FAIL reset_rk_out: %h required 0", rk_out); end
  endtask

  task automatic test_forward();
    int lat, beats;
    load(FIPS_KEY, 1'b0);
    wait_valid(lat);
    checks++;
    if (lat != 10) begin errors++; $display("FAIL forward_latency: %0d required 10", lat); end
    drain(1'b0, 1'b0, -1, beats);
    check_beats("forward", beats);
    checks++;
    if (first_rk !== FIPS_K10) begin errors++; $display("FAIL fips_k10: %h required %h", first_rk, FIPS_K10); end
    checks++;
    if (k1_seen !== FIPS_K1) begin errors++; $display("FAIL fips_k1: %h required %h", k1_seen, FIPS_K1); end
  endtask

  task automatic test_direct();
    int lat, beats;
    load(FIPS_KEY, 1'b1);
    wait_valid(lat);
    checks++;
    if (lat != 0) begin errors++; $display("FAIL direct_latency: %0d required 0", lat); end
    drain(1'b0, 1'b0, -1, beats);
    check_beats("direct", beats);
  endtask

  task automatic test_backpressure();
    int lat, beats;
    for (int i = 0; i < 2; i++) begin
      load({$urandom, $urandom, $urandom, $urandom}, 1'(i));
      wait_valid(lat);
      drain(1'b1, 1'b0, -1, beats);
      check_beats("backpressure", beats);
    end
  endtask

  task automatic test_reset_mid();
    int lat, beats;
    load(FIPS_KEY, 1'b0);
    repeat (4) @(negedge clk);
    do_reset();
    load(SEQ_KEY, 1'b1);
    wait_valid(lat);
    drain(1'b0, 1'b0, 6, beats);
    checks++;
    if (rk_round !== 4'd6) begin errors++; $display("FAIL reset_mid_round: %0d required 6", rk_round); end
    do_reset();
    load(SEQ_KEY, 1'b0);
    wait_valid(lat);
    drain(1'b0, 1'b0, -1, beats);
    check_beats("after_reset", beats);
  endtask

  task automatic test_ignored_load();
    int lat, beats;
    load(FIPS_KEY, 1'b0);
    repeat (3) @(negedge clk);
    key_in    = SEQ_KEY;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    wait_valid(lat);
    drain(1'b0, 1'b1, -1, beats);
    check_beats("ignored_load", beats);
  endtask

  task automatic test_back_to_back();
    int lat, beats;
    load(FIPS_KEY, 1'b0);
    wait_valid(lat);
    drain(1'b0, 1'b0, -1, beats);
    check_beats("b2b_first", beats);
    load(SEQ_KEY, 1'b0);
    wait_valid(lat);
    checks++;
    if (lat != 10) begin errors++; $display("FAIL b2b_latency: %0d required 10", lat); end
    drain(1'b0, 1'b0, -1, beats);
    check_beats("b2b_second", beats);
    checks++;
    if (first_rk !== SEQ_K10) begin errors++; $display("FAIL b2b_k10: %h required %h", first_rk, SEQ_K10); end
  endtask

  initial begin
    reset       = 1'b1;
    key_valid   = 1'b0;
    key_in      = '0;
    key_is_last = 1'b0;
    rk_ready    = 1'b0;
    first_rk    = '0;
    k1_seen     = '0;
    build_sbox();
    test_reset();
    test_forward();
    test_direct();
    test_backpressure();
    test_reset_mid();
    test_ignored_load();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
